// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACK_ADDR = 3'd2,
        ST_DATA     = 3'd3,
        ST_ACK_DATA = 3'd4,
        ST_IGNORE   = 3'd5
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h3C;

    // SDA line levels seen by the controller during the ninth clock
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_sync.sv
// rtl/i2c_sync.sv - bus input synchronizer and edge detector for SCL/SDA
module i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall,
    output logic scl_lvl,
    output logic sda_lvl
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    // Shift raw levels through the sync chain; everything resets to bus-idle high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= SYNC_STAGES'({scl_sync, scl_in});
            sda_sync <= SYNC_STAGES'({sda_sync, sda_in});
            scl_prev <= scl_lvl;
            sda_prev <= sda_lvl;
        end
    end

    assign scl_lvl  = scl_sync[SYNC_STAGES-1];
    assign sda_lvl  = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_lvl & ~scl_prev;
    assign scl_fall = ~scl_lvl & scl_prev;
    assign sda_rise = sda_lvl & ~sda_prev;
    assign sda_fall = ~sda_lvl & sda_prev;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - write-only I2C target that ACKs its address and every data byte
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic scl_lvl;
    logic sda_lvl;

    i2c_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_rise (sda_rise),
        .sda_fall (sda_fall),
        .scl_lvl  (scl_lvl),
        .sda_lvl  (sda_lvl)
    );

    state_t      state;
    logic [6:0]  shift;
    logic [3:0]  count;

    logic        start_det;
    logic        stop_det;
    logic [7:0]  next_byte;
    logic [3:0]  count_inc;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign next_byte = {shift, sda_lvl};
    assign count_inc = (count >= BITS_PER_BYTE) ? BITS_PER_BYTE : count + 4'd1;

    // Protocol FSM; bus conditions outrank SCL edges, outputs are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shift    <= 7'd0;
            count    <= 4'd0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                count  <= 4'd0;
                sda_oe <= ~NACK_LVL;
                busy   <= 1'b0;
            end else if (start_det) begin
                state  <= ST_ADDR;
                count  <= 4'd0;
                sda_oe <= ~NACK_LVL;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift <= next_byte[6:0];
                            count <= count_inc;
                            if (count_inc == BITS_PER_BYTE) begin
                                if (next_byte == {DEV_ADDR, 1'b0}) begin
                                    state <= ST_ACK_ADDR;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    // First fall after the byte starts the ACK pulse, the second ends it
                    ST_ACK_ADDR, ST_ACK_DATA: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= ~ACK_LVL;
                            end else begin
                                sda_oe <= ~NACK_LVL;
                                state  <= ST_DATA;
                                count  <= 4'd0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise) begin
                            shift <= next_byte[6:0];
                            count <= count_inc;
                            if (count_inc == BITS_PER_BYTE) begin
                                rx_data  <= next_byte;
                                rx_valid <= 1'b1;
                                state    <= ST_ACK_DATA;
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
